// File: rtl/iic_s_interface.sv
// I2C target that exposes a byte-wide register pointer and one-cycle write/read strobes
// to a user register bank. SCL/SDA are oversampled by clk; SDA is open-drain.
module iic_s_interface #(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iic_scl,
  inout  wire        iic_sda,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK
  } state_t;

  logic scl_p0_q, scl_p1_q, scl_p2_q;
  logic sda_p0_q, sda_p1_q, sda_p2_q;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       we_q, we_d;
  logic       re_q, re_d;
  logic       re_dly_q;
  logic       busy_q, busy_d;
  logic       oe_q, oe_d;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_next;

  // Synchroniser stages p0/p1; p2 is the previous synced value for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_p0_q <= 1'b1;
      scl_p1_q <= 1'b1;
      scl_p2_q <= 1'b1;
      sda_p0_q <= 1'b1;
      sda_p1_q <= 1'b1;
      sda_p2_q <= 1'b1;
    end else begin
      scl_p0_q <= iic_scl;
      scl_p1_q <= scl_p0_q;
      scl_p2_q <= scl_p1_q;
      sda_p0_q <= iic_sda;
      sda_p1_q <= sda_p0_q;
      sda_p2_q <= sda_p1_q;
    end
  end

  assign scl_rise  = scl_p1_q & ~scl_p2_q;
  assign scl_fall  = ~scl_p1_q & scl_p2_q;
  assign start_det = scl_p1_q & ~sda_p1_q & sda_p2_q;
  assign stop_det  = scl_p1_q & sda_p1_q & ~sda_p2_q;
  assign rx_next   = {rx_q[6:0], sda_p1_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    ptr_d   = ptr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    busy_d  = busy_q;
    oe_d    = oe_q;

    // Write pointer advances the cycle after the strobe; read data lands one cycle after reg_re
    if (we_q)     ptr_d = ptr_q + 8'd1;
    if (re_dly_q) tx_d  = reg_rdata;

    if (start_det) begin
      state_d = ADDR;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (stop_det) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        // cnt reaching 8 marks a complete byte awaiting the falling edge that opens the ACK slot
        ADDR, PTR, WDATA: begin
          if (scl_rise && cnt_q < 4'd8) begin
            rx_d  = rx_next;
            cnt_d = cnt_q + 4'd1;
            if (state_q == WDATA && cnt_q == 4'd7) begin
              we_d    = 1'b1;
              wdata_d = rx_next;
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d = 4'd0;
            oe_d  = 1'b1;
            if (state_q == ADDR) begin
              if (rx_q[7:1] == DEV_ADDR) begin
                state_d = ADDR_ACK;
                busy_d  = 1'b1;
                re_d    = rx_q[0];
              end else begin
                state_d = IDLE;
                oe_d    = 1'b0;
              end
            end else if (state_q == PTR) begin
              ptr_d   = rx_q;
              state_d = PTR_ACK;
            end else begin
              state_d = WDATA_ACK;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = 4'd0;
            if (rx_q[0]) begin
              state_d = RDATA;
              oe_d    = ~tx_q[7];
              tx_d    = {tx_q[6:0], 1'b0};
            end else begin
              state_d = PTR;
              oe_d    = 1'b0;
            end
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            state_d = WDATA;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
          end
        end
        RDATA: begin
          if (scl_rise && cnt_q < 4'd8) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              state_d = RACK;
              cnt_d   = 4'd0;
              oe_d    = 1'b0;
            end else begin
              oe_d = ~tx_q[7];
              tx_d = {tx_q[6:0], 1'b0};
            end
          end
        end
        // Master ACK fetches the next byte now so it is loaded before this slot's falling edge
        RACK: begin
          if (scl_rise) begin
            if (sda_p1_q) begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end else begin
              ptr_d = ptr_q + 8'd1;
              re_d  = 1'b1;
            end
          end else if (scl_fall) begin
            state_d = RDATA;
            oe_d    = ~tx_q[7];
            tx_d    = {tx_q[6:0], 1'b0};
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      ptr_q    <= 8'h00;
      wdata_q  <= 8'h00;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      re_dly_q <= 1'b0;
      busy_q   <= 1'b0;
      oe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      re_q     <= re_d;
      re_dly_q <= re_q;
      busy_q   <= busy_d;
      oe_q     <= oe_d;
    end
  end

  always_ff @(posedge clk) begin
    rx_q <= rx_d;
    tx_q <= tx_d;
  end

  assign iic_sda   = oe_q ? 1'b0 : 1'bz;
  assign reg_addr  = ptr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_iic_s_interface.sv
// Bench for iic_s_interface: bit-banged I2C master, register bank responder and a
// transaction-level model of pointer/bank contents.
`timescale 1ns/1ps
module tb_iic_s_interface;
  localparam int Q = 6;
  localparam logic [6:0] DEV = 7'h50;

  logic clk = 1'b0, rst = 1'b1, scl = 1'b1, m_low = 1'b0;
  wire  sda_bus;
  logic [7:0] reg_addr, reg_wdata;
  logic [7:0] reg_rdata = 8'h00;
  logic reg_we, reg_re, busy;

  assign sda_bus = m_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  iic_s_interface #(.DEV_ADDR(DEV)) dut (
    .clk(clk), .rst(rst), .iic_scl(scl), .iic_sda(sda_bus),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0, both_hi = 0;
  logic [7:0] bank [256];
  logic [7:0] exp_bank [256];
  logic [7:0] mdl_ptr = 8'h00;
  logic [7:0] we_a_q[$], we_d_q[$], re_a_q[$];
  bit rd_pend = 1'b0;
  logic [7:0] rd_addr = 8'h00;

  // Register bank: read data is garbage during the strobe cycle, valid from the next cycle
  always @(negedge clk) begin
    if (reg_we === 1'b1 && reg_re === 1'b1) both_hi++;
    if (rd_pend) begin reg_rdata = bank[rd_addr]; rd_pend = 1'b0; end
    if (reg_re === 1'b1) begin
      re_a_q.push_back(reg_addr); rd_addr = reg_addr; rd_pend = 1'b1; reg_rdata = 8'($urandom);
    end
    if (reg_we === 1'b1) begin
      we_a_q.push_back(reg_addr); we_d_q.push_back(reg_wdata); bank[reg_addr] = reg_wdata;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    wait_clk(Q); m_low = 1'b0; wait_clk(Q); scl = 1'b1; wait_clk(Q); m_low = 1'b1; wait_clk(Q); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(Q); m_low = 1'b1; wait_clk(Q); scl = 1'b1; wait_clk(Q); m_low = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_bit(input bit b, output bit seen);
    wait_clk(Q); m_low = ~b; wait_clk(Q); scl = 1'b1; wait_clk(Q);
    seen = sda_bus; wait_clk(Q); scl = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] d, output bit ack);
    bit s;
    for (int i = 7; i >= 0; i--) i2c_bit(d[i], s);
    i2c_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic rd_byte(input bit mack, output logic [7:0] d);
    bit s;
    for (int i = 7; i >= 0; i--) begin i2c_bit(1'b1, s); d[i] = s; end
    i2c_bit(~mack, s);
  endtask

  task automatic clear_logs();
    we_a_q.delete(); we_d_q.delete(); re_a_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; wait_clk(3); rst = 1'b0; wait_clk(2);
    mdl_ptr = 8'h00;
    n_cmp++; if (reg_addr !== 8'h00) begin $display("FAIL rst_addr got=%h exp=00", reg_addr); n_err++; end
    n_cmp++; if (reg_wdata !== 8'h00) begin $display("FAIL rst_wdata got=%h exp=00", reg_wdata); n_err++; end
    n_cmp++; if ({reg_we, reg_re} !== 2'b00) begin $display("FAIL rst_strobes got=%b exp=00", {reg_we, reg_re}); n_err++; end
    n_cmp++; if (busy !== 1'b0) begin $display("FAIL rst_busy got=%b exp=0", busy); n_err++; end
    n_cmp++; if (sda_bus !== 1'b1) begin $display("FAIL rst_sda got=%b exp=1", sda_bus); n_err++; end
  endtask

  task automatic test_write_basic();
    bit a0, a1, a2;
    clear_logs();
    i2c_start();
    wr_byte(8'hA0, a0);
    n_cmp++; if (busy !== 1'b1) begin $display("FAIL wb_busy got=%b exp=1", busy); n_err++; end
    wr_byte(8'hB1, a1);
    wr_byte(8'hDA, a2);
    i2c_stop(); wait_clk(4);
    exp_bank[8'hB1] = 8'hDA; mdl_ptr = 8'hB2;
    n_cmp++; if ({a0, a1, a2} !== 3'b111) begin $display("FAIL wb_acks got=%b exp=111", {a0, a1, a2}); n_err++; end
    n_cmp++; if (we_a_q.size() != 1) begin $display("FAIL wb_we_count got=%0d exp=1", we_a_q.size()); n_err++; end
    if (we_a_q.size() >= 1) begin
      n_cmp++; if (we_a_q[0] !== 8'hB1 || we_d_q[0] !== 8'hDA) begin
        $display("FAIL wb_we got=%h/%h exp=B1/DA", we_a_q[0], we_d_q[0]); n_err++; end
    end
    n_cmp++; if (reg_addr !== 8'hB2) begin $display("FAIL wb_ptr got=%h exp=B2", reg_addr); n_err++; end
    n_cmp++; if (busy !== 1'b0) begin $display("FAIL wb_busy_end got=%b exp=0", busy); n_err++; end
  endtask

  task automatic test_read_rstart();
    bit a0, a1, a2;
    logic [7:0] d;
    clear_logs();
    i2c_start(); wr_byte(8'hA0, a0); wr_byte(8'hB1, a1);
    i2c_start(); wr_byte(8'hA1, a2);
    rd_byte(1'b0, d);
    n_cmp++; if (busy !== 1'b0) begin $display("FAIL rd_busy_nack got=%b exp=0", busy); n_err++; end
    i2c_stop(); wait_clk(4);
    mdl_ptr = 8'hB1;
    n_cmp++; if ({a0, a1, a2} !== 3'b111) begin $display("FAIL rd_acks got=%b exp=111", {a0, a1, a2}); n_err++; end
    n_cmp++; if (d !== 8'hDA) begin $display("FAIL rd_data got=%h exp=DA", d); n_err++; end
    n_cmp++; if (re_a_q.size() != 1 || re_a_q[0] !== 8'hB1) begin
      $display("FAIL rd_re got_n=%0d exp=1 at B1", re_a_q.size()); n_err++; end
    n_cmp++; if (reg_addr !== 8'hB1) begin $display("FAIL rd_ptr got=%h exp=B1", reg_addr); n_err++; end
  endtask

  task automatic test_seq_read_wrap();
    bit a0, a1, a2;
    logic [7:0] d;
    logic [7:0] exp_a [3];
    exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00;
    clear_logs();
    i2c_start(); wr_byte(8'hA0, a0); wr_byte(8'hFE, a1);
    i2c_start(); wr_byte(8'hA1, a2);
    n_cmp++; if ({a0, a1, a2} !== 3'b111) begin $display("FAIL wrap_acks got=%b exp=111", {a0, a1, a2}); n_err++; end
    for (int i = 0; i < 3; i++) begin
      rd_byte(i < 2, d);
      n_cmp++; if (d !== exp_bank[exp_a[i]]) begin
        $display("FAIL wrap_data%0d got=%h exp=%h", i, d, exp_bank[exp_a[i]]); n_err++; end
    end
    i2c_stop(); wait_clk(4);
    mdl_ptr = 8'h00;
    n_cmp++; if (re_a_q.size() != 3) begin $display("FAIL wrap_re_count got=%0d exp=3", re_a_q.size()); n_err++; end
    for (int i = 0; i < 3 && i < re_a_q.size(); i++) begin
      n_cmp++; if (re_a_q[i] !== exp_a[i]) begin
        $display("FAIL wrap_re%0d got=%h exp=%h", i, re_a_q[i], exp_a[i]); n_err++; end
    end
    n_cmp++; if (reg_addr !== 8'h00) begin $display("FAIL wrap_ptr got=%h exp=00", reg_addr); n_err++; end
  endtask

  task automatic test_wrong_addr();
    bit a0, a1;
    clear_logs();
    i2c_start(); wr_byte(8'hA2, a0);
    n_cmp++; if (a0 !== 1'b0) begin $display("FAIL wa_ack got=%b exp=0", a0); n_err++; end
    n_cmp++; if (busy !== 1'b0) begin $display("FAIL wa_busy got=%b exp=0", busy); n_err++; end
    wr_byte(8'h33, a1);
    n_cmp++; if (a1 !== 1'b0) begin $display("FAIL wa_ack2 got=%b exp=0", a1); n_err++; end
    i2c_stop(); wait_clk(4);
    n_cmp++; if (we_a_q.size() + re_a_q.size() != 0) begin
      $display("FAIL wa_strobes got=%0d exp=0", we_a_q.size() + re_a_q.size()); n_err++; end
  endtask

  task automatic test_stop_mid_byte();
    bit a0, a1, s;
    logic [7:0] p;
    p = 8'($urandom_range(1, 254));
    clear_logs();
    i2c_start(); wr_byte(8'hA0, a0); wr_byte(p, a1);
    for (int i = 0; i < 4; i++) i2c_bit(1'($urandom), s);
    i2c_stop(); wait_clk(4);
    mdl_ptr = p;
    n_cmp++; if ({a0, a1} !== 2'b11) begin $display("FAIL smb_acks got=%b exp=11", {a0, a1}); n_err++; end
    n_cmp++; if (we_a_q.size() != 0) begin $display("FAIL smb_we got=%0d exp=0", we_a_q.size()); n_err++; end
    n_cmp++; if (sda_bus !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL smb_idle got sda=%b busy=%b exp 1/0", sda_bus, busy); n_err++; end
    n_cmp++; if (reg_addr !== p) begin $display("FAIL smb_ptr got=%h exp=%h", reg_addr, p); n_err++; end
  endtask

  task automatic txn_write(input logic [7:0] p, input int n, input string nm);
    bit a;
    int nack = 0;
    logic [7:0] dl[$];
    clear_logs();
    i2c_start();
    wr_byte(8'hA0, a); nack += int'(!a);
    wr_byte(p, a); nack += int'(!a);
    for (int i = 0; i < n; i++) begin
      dl.push_back(8'($urandom));
      wr_byte(dl[i], a); nack += int'(!a);
      exp_bank[p + 8'(i)] = dl[i];
    end
    i2c_stop(); wait_clk(4);
    mdl_ptr = p + 8'(n);
    n_cmp++; if (nack != 0) begin $display("FAIL %s_acks got_nacks=%0d exp=0", nm, nack); n_err++; end
    n_cmp++; if (we_a_q.size() != n) begin $display("FAIL %s_we_count got=%0d exp=%0d", nm, we_a_q.size(), n); n_err++; end
    for (int i = 0; i < n && i < we_a_q.size(); i++) begin
      n_cmp++; if (we_a_q[i] !== p + 8'(i) || we_d_q[i] !== dl[i]) begin
        $display("FAIL %s_we%0d got=%h/%h exp=%h/%h", nm, i, we_a_q[i], we_d_q[i], p + 8'(i), dl[i]); n_err++; end
    end
    n_cmp++; if (reg_addr !== mdl_ptr) begin $display("FAIL %s_ptr got=%h exp=%h", nm, reg_addr, mdl_ptr); n_err++; end
  endtask

  task automatic txn_read(input bit set, input logic [7:0] p, input int n, input string nm);
    bit a;
    int nack = 0;
    logic [7:0] d, base;
    clear_logs();
    i2c_start();
    if (set) begin
      wr_byte(8'hA0, a); nack += int'(!a);
      wr_byte(p, a); nack += int'(!a);
      i2c_start();
      mdl_ptr = p;
    end
    base = mdl_ptr;
    wr_byte(8'hA1, a); nack += int'(!a);
    n_cmp++; if (nack != 0) begin $display("FAIL %s_acks got_nacks=%0d exp=0", nm, nack); n_err++; end
    for (int i = 0; i < n; i++) begin
      rd_byte(i < n - 1, d);
      n_cmp++; if (d !== exp_bank[base + 8'(i)]) begin
        $display("FAIL %s_data%0d got=%h exp=%h", nm, i, d, exp_bank[base + 8'(i)]); n_err++; end
    end
    n_cmp++; if (busy !== 1'b0) begin $display("FAIL %s_busy got=%b exp=0", nm, busy); n_err++; end
    i2c_stop(); wait_clk(4);
    mdl_ptr = base + 8'(n - 1);
    n_cmp++; if (re_a_q.size() != n) begin $display("FAIL %s_re_count got=%0d exp=%0d", nm, re_a_q.size(), n); n_err++; end
    for (int i = 0; i < n && i < re_a_q.size(); i++) begin
      n_cmp++; if (re_a_q[i] !== base + 8'(i)) begin
        $display("FAIL %s_re%0d got=%h exp=%h", nm, i, re_a_q[i], base + 8'(i)); n_err++; end
    end
    n_cmp++; if (reg_addr !== mdl_ptr) begin $display("FAIL %s_ptr got=%h exp=%h", nm, reg_addr, mdl_ptr); n_err++; end
  endtask

  task automatic test_reset_during_ack();
    bit s;
    clear_logs();
    i2c_start();
    for (int i = 7; i >= 0; i--) i2c_bit(bit'(8'hA0 >> i), s);
    wait_clk(Q); m_low = 1'b0; wait_clk(Q); scl = 1'b1; wait_clk(Q);
    n_cmp++; if (sda_bus !== 1'b0) begin $display("FAIL rda_ack_driven got=%b exp=0", sda_bus); n_err++; end
    rst = 1'b1; wait_clk(1);
    n_cmp++; if (sda_bus !== 1'b1) begin $display("FAIL rda_sda_release got=%b exp=1", sda_bus); n_err++; end
    rst = 1'b0;
    mdl_ptr = 8'h00;
    n_cmp++; if (reg_addr !== 8'h00 || busy !== 1'b0) begin
      $display("FAIL rda_state got ptr=%h busy=%b exp 00/0", reg_addr, busy); n_err++; end
    wait_clk(Q); scl = 1'b0;
    for (int i = 0; i < 8; i++) i2c_bit(1'($urandom), s);
    i2c_bit(1'b1, s);
    n_cmp++; if (s !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL rda_ignore got sda=%b busy=%b exp 1/0", s, busy); n_err++; end
    i2c_stop(); wait_clk(4);
    n_cmp++; if (we_a_q.size() + re_a_q.size() != 0) begin
      $display("FAIL rda_strobes got=%0d exp=0", we_a_q.size() + re_a_q.size()); n_err++; end
    txn_write(8'($urandom), 2, "rda_write");
  endtask

  task automatic test_random();
    int kind;
    for (int t = 0; t < 10; t++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) txn_write(8'($urandom), $urandom_range(0, 3), "rnd_wr");
      else if (kind == 1) txn_read(1'b1, 8'($urandom_range(250, 255)), $urandom_range(1, 3), "rnd_rd_set");
      else txn_read(1'b0, 8'h00, $urandom_range(1, 3), "rnd_rd_cur");
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin bank[i] = 8'($urandom); exp_bank[i] = bank[i]; end
    test_reset();
    test_write_basic();
    test_read_rstart();
    test_seq_read_wrap();
    test_wrong_addr();
    test_stop_mid_byte();
    test_reset_during_ack();
    test_random();
    n_cmp++; if (both_hi != 0) begin $display("FAIL strobe_overlap got=%0d exp=0", both_hi); n_err++; end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
